// File: rtl/tcdm_addr_demux.sv
// TCDM 1-to-NB_OUT address demultiplexer with an in-order read ordering FIFO.
// Unmapped accesses are granted locally; unmapped reads are answered with ERR_DATA.
package tcdm_addr_demux_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    typedef struct packed {
        logic       empty;
        logic       full;
        logic [7:0] push_pointer;
        logic [7:0] pop_pointer;
    } flags_fifo_t;

endpackage

module tcdm_addr_demux
    import tcdm_addr_demux_pkg::*;
#(
    parameter int unsigned NB_OUT          = 4,
    parameter int unsigned NB_RULES        = 4,
    parameter int unsigned DW              = 32,
    parameter int unsigned AW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter logic [31:0] ERR_DATA        = 32'hBADCAB1E
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  addr_map_rule_t [NB_RULES-1:0]     rules_i,
    input  logic                              in_req_i,
    input  logic [AW-1:0]                     in_addr_i,
    input  logic                              in_wen_i,
    input  logic [DW-1:0]                     in_data_i,
    input  logic [DW/8-1:0]                   in_be_i,
    output logic                              in_gnt_o,
    output logic [DW-1:0]                     in_r_data_o,
    output logic                              in_r_valid_o,
    input  logic                              in_r_ready_i,
    output logic [NB_OUT-1:0]                 out_req_o,
    output logic [NB_OUT-1:0][AW-1:0]         out_addr_o,
    output logic [NB_OUT-1:0]                 out_wen_o,
    output logic [NB_OUT-1:0][DW-1:0]         out_data_o,
    output logic [NB_OUT-1:0][DW/8-1:0]       out_be_o,
    input  logic [NB_OUT-1:0]                 out_gnt_i,
    input  logic [NB_OUT-1:0][DW-1:0]         out_r_data_i,
    input  logic [NB_OUT-1:0]                 out_r_valid_i,
    output logic [NB_OUT-1:0]                 out_r_ready_o,
    output flags_fifo_t                       flags_o,
    output logic                              err_o
);

    localparam int unsigned IdxW = (NB_OUT > 1) ? $clog2(NB_OUT) : 1;
    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam logic [DW-1:0] ErrData = DW'(ERR_DATA);

    typedef struct packed {
        logic            err;
        logic [IdxW-1:0] idx;
    } entry_t;

    logic            hit;
    logic [31:0]     hit_idx;
    logic            mapped;
    logic [IdxW-1:0] sel;
    logic            stall;
    logic            push;
    logic            pop;
    logic            empty;
    logic            full;
    logic            err_q;
    logic [PtrW:0]   wr_ptr_q;
    logic [PtrW:0]   rd_ptr_q;
    entry_t          mem_q [MAX_OUTSTANDING];
    entry_t          head;

    // Lowest-numbered matching rule wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned r = 0; r < NB_RULES; r++) begin
            if (!hit && (in_addr_i >= rules_i[r].start_addr[AW-1:0])
                     && (in_addr_i <  rules_i[r].end_addr[AW-1:0])) begin
                hit     = 1'b1;
                hit_idx = rules_i[r].idx;
            end
        end
    end

    assign mapped = hit && (hit_idx < NB_OUT);
    assign sel    = hit_idx[IdxW-1:0];
    // Reads stall on a full FIFO even if a pop frees a slot this cycle.
    assign stall  = ~in_wen_i & full;

    always_comb begin
        out_req_o  = '0;
        out_addr_o = '0;
        out_wen_o  = '0;
        out_data_o = '0;
        out_be_o   = '0;
        if (mapped) begin
            out_req_o[sel]  = in_req_i & ~stall;
            out_addr_o[sel] = in_addr_i;
            out_wen_o[sel]  = in_wen_i;
            out_data_o[sel] = in_data_i;
            out_be_o[sel]   = in_be_i;
        end
    end

    assign in_gnt_o = mapped ? (out_gnt_i[sel] & out_req_o[sel]) : (in_req_i & ~stall);
    assign push     = in_gnt_o & ~in_wen_i;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign head  = mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        in_r_valid_o  = 1'b0;
        in_r_data_o   = '0;
        out_r_ready_o = '0;
        if (!empty) begin
            if (head.err) begin
                in_r_valid_o = 1'b1;
                in_r_data_o  = ErrData;
            end else begin
                in_r_valid_o            = out_r_valid_i[head.idx];
                in_r_data_o             = out_r_data_i[head.idx];
                out_r_ready_o[head.idx] = in_r_ready_i;
            end
        end
    end

    assign pop = in_r_valid_o & in_r_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            err_q <= in_gnt_o & ~mapped;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= '{err: ~mapped, idx: sel};
    end

    assign err_o   = err_q;
    assign flags_o = '{empty:        empty,
                       full:         full,
                       push_pointer: 8'(wr_ptr_q[PtrW-1:0]),
                       pop_pointer:  8'(rd_ptr_q[PtrW-1:0])};

endmodule
